iteration_scheduler: RTL
========================

ITERATION_SCHEDULER -- requirements
Module: iteration_scheduler

Interface
REQ-001 SHALL have parameter NUM_LANES, default 4, number of parallel compute lanes sequenced.
REQ-002 SHALL have parameter CNT_W, default 24, width of iteration count and limit.
REQ-003 SHALL have parameter MAX_ITER, default 24'h3FF, hard ceiling on iterations per job.
REQ-004 SHALL have port aclk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port aresetn  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port clr  input  1  synchronous abort/clear, active-high.
REQ-007 SHALL have port start  input  1  job request, sampled in IDLE only.
REQ-008 SHALL have port iter_limit  input  CNT_W  requested iterations, latched on accepted start.
REQ-009 SHALL have port lane_done  input  NUM_LANES  per-lane one-cycle iteration-complete strobe.
REQ-010 SHALL have port lane_conv  input  NUM_LANES  per-lane converged flag, valid with lane_done.
REQ-011 SHALL have port lane_go  output  NUM_LANES  one-cycle launch strobe per active lane.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.
REQ-013 SHALL have port done  output  1  one-cycle job-complete pulse.
REQ-014 SHALL have port iter_count  output  CNT_W  completed iterations of current/last job.
REQ-015 SHALL have port ovf  output  1  job ended on limit with lanes unconverged.
REQ-016 SHALL have port conv_mask  output  NUM_LANES  lanes converged so far in current/last job.

Function
REQ-017 SHALL implement FSM states IDLE, ISSUE, WAIT, CHECK, DONE.
REQ-018 IDLE: start=1 -> latch limit, clear iter_count/ovf/conv_mask, active_mask=all ones -> ISSUE; start=0 -> stay.
REQ-019 Effective limit SHALL be MAX_ITER when iter_limit==0 or iter_limit>MAX_ITER, else iter_limit.
REQ-020 ISSUE: lane_go=active_mask for exactly that cycle, clear done_seen -> WAIT; lane_go=0 in all other states.
REQ-021 WAIT: for each active lane, lane_done=1 sets done_seen bit and captures lane_conv bit; when done_seen (including this cycle's strobes) equals active_mask -> CHECK.
REQ-022 lane_done from inactive lanes, or in any state other than WAIT, SHALL be ignored.
REQ-023 CHECK: iter_count+=1; conv_mask|=captured conv bits; active_mask&=~captured conv bits.
REQ-024 CHECK: new active_mask==0 -> DONE with ovf=0; else iter_count+1 >= limit -> DONE with ovf=1; else -> ISSUE.
REQ-025 iter_count SHALL saturate at MAX_ITER and never wrap.
REQ-026 DONE: done=1 for one cycle -> IDLE; iter_count, ovf, conv_mask SHALL hold until next accepted start.
REQ-027 start while busy SHALL be ignored with no effect.
REQ-028 clr=1 in any state SHALL -> IDLE next cycle, clear iter_count/ovf/conv_mask/active_mask, suppress done and lane_go; clr has priority over start.
REQ-029 Latency: start sampled at edge k -> lane_go high cycle k+1; final lane_done at edge m -> CHECK at m+1, done high at m+2.

Reset
REQ-030 aresetn=0 SHALL asynchronously force IDLE, lane_go=0, busy=0, done=0, iter_count=0, ovf=0, conv_mask=0.
REQ-031 Reset deassertion mid-job SHALL leave block in IDLE; no done pulse for the aborted job.

Structure
REQ-032 Package iteration_scheduler_pkg SHALL hold the FSM state enum and the NUM_LANES, CNT_W, MAX_ITER defaults.
REQ-033 Iteration count SHALL be one sub-module iter_sat_counter (clear, increment, saturate at MAX_ITER, registered output).

Verification
REQ-034 limit=3, lanes never converge, lane_done all 2 cycles after lane_go -> 3 lane_go bursts, done, iter_count=3, ovf=1, conv_mask=0.
REQ-035 limit=10, lane 2 converges at iter 1, others at iter 4 -> lane_go=4'b1011 from iter 2, done, iter_count=4, ovf=0, conv_mask=4'hF.
REQ-036 iter_limit=0 and iter_limit=24'h5000, no convergence -> iter_count=24'h3FF, ovf=1.
REQ-037 lane_done skewed 1..7 cycles per lane, plus spurious strobes on inactive lanes -> CHECK only after all active lanes reported, counts unaffected.
REQ-038 clr mid-WAIT, then start same cycle as clr -> IDLE, no done, start ignored; start next cycle accepted normally.
REQ-039 aresetn low mid-ISSUE -> all outputs 0 immediately, IDLE after release, start then accepted.

Source files
------------

// File: rtl/iteration_scheduler_pkg.sv
// Shared defaults and FSM state encoding for the iteration scheduler.
package iteration_scheduler_pkg;

    localparam int          DEF_NUM_LANES = 4;
    localparam int          DEF_CNT_W     = 24;
    localparam logic [23:0] DEF_MAX_ITER  = 24'h3FF;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        CHECK,
        DONE
    } sched_state_t;

endpackage

// File: rtl/iteration_scheduler_iter_sat_counter.sv
// Completed-iteration counter: synchronous clear, increment, holds at MAX_ITER.
module iter_sat_counter
    import iteration_scheduler_pkg::*;
#(
    parameter int               CNT_W    = DEF_CNT_W,
    parameter logic [CNT_W-1:0] MAX_ITER = CNT_W'(DEF_MAX_ITER)
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count < MAX_ITER)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/iteration_scheduler.sv
// Sequences iterations over parallel lanes until every lane converges or the limit is hit.
module iteration_scheduler
    import iteration_scheduler_pkg::*;
#(
    parameter int               NUM_LANES = DEF_NUM_LANES,
    parameter int               CNT_W     = DEF_CNT_W,
    parameter logic [CNT_W-1:0] MAX_ITER  = CNT_W'(DEF_MAX_ITER)
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 clr,
    input  logic                 start,
    input  logic [CNT_W-1:0]     iter_limit,
    input  logic [NUM_LANES-1:0] lane_done,
    input  logic [NUM_LANES-1:0] lane_conv,
    output logic [NUM_LANES-1:0] lane_go,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     iter_count,
    output logic                 ovf,
    output logic [NUM_LANES-1:0] conv_mask
);

    sched_state_t         state_q, state_d;
    logic [CNT_W-1:0]     limit_q;
    logic [CNT_W-1:0]     eff_limit;
    logic [NUM_LANES-1:0] active_q, seen_q, cap_q, conv_q;
    logic                 ovf_q;
    logic [NUM_LANES-1:0] hit, seen_now, new_active;
    logic [CNT_W:0]       next_count;
    logic                 limit_hit, accept, count_clr, count_inc;

    assign accept     = (state_q == IDLE) && start && !clr;
    assign eff_limit  = ((iter_limit == '0) || (iter_limit > MAX_ITER)) ? MAX_ITER : iter_limit;
    assign hit        = lane_done & active_q;
    assign seen_now   = seen_q | hit;
    assign new_active = active_q & ~cap_q;
    assign next_count = {1'b0, iter_count} + (CNT_W+1)'(1);
    assign limit_hit  = next_count >= {1'b0, limit_q};
    assign count_clr  = clr || accept;
    assign count_inc  = (state_q == CHECK) && !clr;

    iter_sat_counter #(
        .CNT_W    (CNT_W),
        .MAX_ITER (MAX_ITER)
    ) u_iter_cnt (
        .aclk    (aclk),
        .aresetn (aresetn),
        .clr     (count_clr),
        .inc     (count_inc),
        .count   (iter_count)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (seen_now == active_q) state_d = CHECK;
            CHECK:   state_d = ((new_active == '0) || limit_hit) ? DONE : ISSUE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (clr) state_d = IDLE;
    end

    // Lanes that report converged in an iteration drop out of all later launches.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= IDLE;
            limit_q  <= '0;
            active_q <= '0;
            seen_q   <= '0;
            cap_q    <= '0;
            conv_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (clr) begin
                active_q <= '0;
                seen_q   <= '0;
                cap_q    <= '0;
                conv_q   <= '0;
                ovf_q    <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: if (start) begin
                        limit_q  <= eff_limit;
                        active_q <= '1;
                        conv_q   <= '0;
                        ovf_q    <= 1'b0;
                    end
                    ISSUE: begin
                        seen_q <= '0;
                        cap_q  <= '0;
                    end
                    WAIT: begin
                        seen_q <= seen_now;
                        cap_q  <= (cap_q & ~hit) | (lane_conv & hit);
                    end
                    CHECK: begin
                        conv_q   <= conv_q | cap_q;
                        active_q <= new_active;
                        ovf_q    <= (new_active != '0) && limit_hit;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign lane_go   = ((state_q == ISSUE) && !clr) ? active_q : '0;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE) && !clr;
    assign ovf       = ovf_q;
    assign conv_mask = conv_q;

endmodule
